// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that holds the architectural HI/LO registers.
// The 64-bit result is computed when the op is accepted and committed to HI/LO when the busy countdown ends.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        r_pend;
  logic               r_wr;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_b_zero;
  logic               w_div_ovf;
  logic signed [31:0] w_as;
  logic signed [31:0] w_bs;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0]        w_bu;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [63:0]        w_result;
  logic               w_wr;
  logic [CNT_W-1:0]   w_cycles;

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Behavioural arithmetic: pick the {hi,lo} result and commit enable for the requested op.
  always_comb begin
    w_result  = 64'd0;
    w_wr      = 1'b0;
    w_cycles  = MULT_N;
    w_prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    w_prod_u  = {32'd0, a} * {32'd0, b};
    w_b_zero  = (b == 32'd0);
    w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // Divisor forced to 1 in the cases handled separately so the dividers never see 0 or overflow.
    w_as      = $signed(a);
    w_bs      = (w_b_zero || w_div_ovf) ? 32'sd1 : $signed(b);
    w_sq      = w_as / w_bs;
    w_sr      = w_as % w_bs;
    w_bu      = w_b_zero ? 32'd1 : b;
    w_uq      = a / w_bu;
    w_ur      = a % w_bu;
    case (op)
      OP_MULT: begin
        w_result = w_prod_s;
        w_wr     = 1'b1;
        w_cycles = MULT_N;
      end
      OP_MULTU: begin
        w_result = w_prod_u;
        w_wr     = 1'b1;
        w_cycles = MULT_N;
      end
      OP_DIV: begin
        w_result = w_div_ovf ? {32'd0, 32'h8000_0000} : {w_sr, w_sq};
        w_wr     = !w_b_zero;
        w_cycles = DIV_N;
      end
      OP_DIVU: begin
        w_result = {w_ur, w_uq};
        w_wr     = !w_b_zero;
        w_cycles = DIV_N;
      end
      default: begin
        w_result = 64'd0;
        w_wr     = 1'b0;
        w_cycles = MULT_N;
      end
    endcase
  end

  // IDLE/RUN control, busy countdown, and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_pend  <= 64'd0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_pend  <= w_result;
                r_wr    <= w_wr;
                r_cnt   <= w_cycles;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            if (r_wr) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table plus hand-written multi-cycle sequences for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Count consecutive busy samples (one per negedge), bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Present one op for one edge, then return at the first negedge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    int idle;
    int n1;
    int n2;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'b011, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
    vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'b100, 32'h1111_1111, 32'h0000_0000, 0,  32'h1111_1111, 32'h8000_0000};
    vecs[6]  = '{3'b101, 32'h2222_2222, 32'h0000_0000, 0,  32'h1111_1111, 32'h2222_2222};
    vecs[7]  = '{3'b011, 32'h0000_0005, 32'h0000_0000, 10, 32'h1111_1111, 32'h2222_2222};
    vecs[8]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[10] = '{3'b110, 32'hDEAD_BEEF, 32'h0000_0003, 0,  32'h0000_0001, 32'hFFFF_FFFD};
    vecs[11] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};

    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    // Table-driven vectors: busy length, then HI/LO.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      count_busy(cnt);
      check($sformatf("v%0d_cycles", i), 64'(cnt), 64'(vecs[i].cycles));
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // MTLO pulsed while a MULT is busy is dropped.
    issue(3'b000, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1;
    op    = 3'b101;
    a     = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    count_busy(cnt);
    check("ign_cycles", 64'(cnt + 2), 64'd5);
    check("ign_hi", 64'(hi), 64'h0);
    check("ign_lo", 64'(lo), 64'd12);
    issue(3'b101, 32'h1234_5678, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h1234_5678);
    check("mtlo_busy", 64'(busy), 64'h0);
    check("mtlo_hi", 64'(hi), 64'h0);

    // Back-to-back: start held high, DIVU taken at first edge with busy=0.
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd2;
    b     = 32'd3;
    @(negedge clk);
    op = 3'b011;
    a  = 32'd100;
    b  = 32'd7;
    count_busy(n1);
    check("b2b_mult_lo", 64'(lo), 64'd6);
    idle = 0;
    while (!busy && idle < 5) begin
      idle++;
      @(negedge clk);
    end
    start = 1'b0;
    count_busy(n2);
    check("b2b_run1", 64'(n1), 64'd5);
    check("b2b_idle", 64'(idle), 64'd1);
    check("b2b_run2", 64'(n2), 64'd10);
    check("b2b_hi", 64'(hi), 64'd2);
    check("b2b_lo", 64'(lo), 64'd14);

    // Reset during DIV with counter at 4 aborts it and the result never lands.
    issue(3'b100, 32'hAAAA_5555, 32'd0);
    issue(3'b010, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    check("rst_mid_busy_pre", 64'(busy), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_hi", 64'(hi), 64'h0);
    check("rst_mid_lo", 64'(lo), 64'h0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_after_busy", 64'(busy), 64'h0);
    check("rst_after_hi", 64'(hi), 64'h0);
    check("rst_after_lo", 64'(lo), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
